// File: rtl/lock_seq_ctrl.sv
// ============================================================================
// lock_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for the digital lock datapath. Collects a code entered
// one nibble at a time, compares it against the stored code on an explicit
// enter strobe, drives a timed unlock pulse, counts consecutive wrong attempts
// and enforces a timed alarm lockout.
//
// Optional feature (compile-time macro):
//   LOCK_SEQ_CTRL_CHANGE_EN  - when defined, change_req in OPEN moves to
//                              NEWCODE and a full-length entry replaces the
//                              stored code. When undefined, change_req is
//                              ignored and the stored code is DEFAULT_CODE.
//
// Parameters:
//   NDIG          digits per code (2..8)
//   MAX_TRIES     consecutive wrong attempts that trigger ALARM (1..7)
//   UNLOCK_CYCLES cycles unlock stays high after a match (>=1)
//   LOCK_CYCLES   ALARM lockout duration in cycles (>=1)
//   DEFAULT_CODE  code loaded at reset, 4*NDIG bits
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   digit        in   keypad nibble
//   digit_valid  in   single-cycle strobe qualifying digit
//   enter        in   single-cycle strobe, submit the entry
//   change_req   in   request a code change (honoured only in OPEN)
//   unlock       out  actuator drive
//   buzzer       out  alarm sounder
//   lockout      out  inputs are being ignored (ALARM)
//   attempts     out  consecutive wrong-attempt count
//   state        out  FSM state: IDLE=0 ENTRY=1 CHECK=2 OPEN=3 ALARM=4 NEWCODE=5
//
// All inputs pass through one register stage before the FSM acts on them, so
// no input reaches an output combinationally. An enter sampled at edge n
// yields CHECK after edge n+1 and the verdict state after edge n+2.
// ============================================================================
module lock_seq_ctrl #(
    parameter int                NDIG          = 4,
    parameter int                MAX_TRIES     = 3,
    parameter int                UNLOCK_CYCLES = 8,
    parameter int                LOCK_CYCLES   = 16,
    parameter logic [4*NDIG-1:0] DEFAULT_CODE  = 16'h1234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       enter,
    input  logic       change_req,
    output logic       unlock,
    output logic       buzzer,
    output logic       lockout,
    output logic [2:0] attempts,
    output logic [2:0] state
);

    // ------------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------------
    localparam int CODE_W = 4 * NDIG;
    localparam int CW     = $clog2(NDIG + 1);
    localparam int TMAX   = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [CW-1:0] FULL        = CW'(NDIG);
    localparam logic [2:0]    TRIES_LIMIT = 3'(MAX_TRIES);
    localparam logic [2:0]    ATT_MAX     = 3'd7;
    localparam logic [TW-1:0] T_UNLOCK    = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] T_LOCK      = TW'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_ALARM   = 3'd4,
        S_NEWCODE = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------------
    // Input capture stage
    // ------------------------------------------------------------------------
    logic [3:0] digit_r;
    logic       dv_r;
    logic       en_r;
    logic       chg_r;
    logic       keys_open;

    // Strobes seen while OPEN or ALARM are discarded at capture time, so a
    // key pressed in the last cycle of those states cannot leak into IDLE.
    assign keys_open = (state_q != S_OPEN) && (state_q != S_ALARM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_r <= 4'h0;
            dv_r    <= 1'b0;
            en_r    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            digit_r <= digit;
            dv_r    <= digit_valid && keys_open;
            en_r    <= enter && keys_open;
        end
    end

`ifdef LOCK_SEQ_CTRL_CHANGE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg_r <= 1'b0;
        end else begin
            chg_r <= change_req && (state_q == S_OPEN);
        end
    end
`else
    // Code change is compiled out: the request is never acted upon.
    logic unused_change;
    assign unused_change = change_req;
    assign chg_r         = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [CODE_W-1:0] entry_q;
    logic [CW-1:0]     count_q;
    logic [TW-1:0]     timer_q;
    logic [2:0]        attempts_q;
    logic [CODE_W-1:0] code;

    logic       collecting;
    logic       take_digit;
    logic       clear_entry;
    logic       match;
    logic       timer_last;
    logic [2:0] attempts_inc;

    assign collecting = (state_q == S_IDLE) || (state_q == S_ENTRY) ||
                        (state_q == S_NEWCODE);

    // enter has priority over a digit strobed in the same cycle; digits past
    // NDIG are dropped so the buffer keeps the first NDIG entered.
    assign take_digit = collecting && dv_r && !en_r && (count_q != FULL);

    assign clear_entry = (state_q == S_CHECK) ||
                         ((state_q == S_OPEN) && chg_r) ||
                         ((state_q == S_NEWCODE) && en_r);

    assign match        = (count_q == FULL) && (entry_q == code);
    assign attempts_inc = (attempts_q == ATT_MAX) ? ATT_MAX : attempts_q + 3'd1;
    assign timer_last   = (timer_q <= TW'(1));

    // Entry buffer and digit count. First digit ends up in the MSB nibble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
            count_q <= '0;
        end else if (clear_entry) begin
            entry_q <= '0;
            count_q <= '0;
        end else if (take_digit) begin
            entry_q <= {entry_q[CODE_W-5:0], digit_r};
            count_q <= count_q + CW'(1);
        end
    end

    // Timer: loaded by the CHECK verdict, counts down through OPEN / ALARM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (match) begin
                        timer_q <= T_UNLOCK;
                    end else if (attempts_inc >= TRIES_LIMIT) begin
                        timer_q <= T_LOCK;
                    end
                end
                S_OPEN, S_ALARM: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Consecutive wrong-attempt counter, saturating at 7. Cleared only by a
    // match or by the end of the alarm lockout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attempts_q <= 3'd0;
        end else if (state_q == S_CHECK) begin
            attempts_q <= match ? 3'd0 : attempts_inc;
        end else if ((state_q == S_ALARM) && timer_last) begin
            attempts_q <= 3'd0;
        end
    end

`ifdef LOCK_SEQ_CTRL_CHANGE_EN
    logic [CODE_W-1:0] code_q;
    logic              code_we;

    // Only a complete NDIG-digit entry replaces the code; a short one is
    // discarded and the old code stays in force.
    assign code_we = (state_q == S_NEWCODE) && en_r && (count_q == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the code register is reset on purpose: reset has to
            // restore the factory code, not keep whatever the user stored.
            code_q <= DEFAULT_CODE;
        end else if (code_we) begin
            code_q <= entry_q;
        end
    end

    assign code = code_q;
`else
    assign code = DEFAULT_CODE;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is
        // inferred when a branch has nothing to say.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en_r) begin
                    state_d = S_CHECK;
                end else if (dv_r) begin
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (en_r) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (match) begin
                    state_d = S_OPEN;
                end else if (attempts_inc >= TRIES_LIMIT) begin
                    state_d = S_ALARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OPEN: begin
                // A change request wins over the unlock timeout.
                if (chg_r) begin
                    state_d = S_NEWCODE;
                end else if (timer_last) begin
                    state_d = S_IDLE;
                end
            end
            S_ALARM: begin
                if (timer_last) begin
                    state_d = S_IDLE;
                end
            end
            S_NEWCODE: begin
                // No timeout: leaves only on enter, full entry or not.
                if (en_r) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode (pure function of the state register)
    // ------------------------------------------------------------------------
    always_comb begin
        unlock  = 1'b0;
        buzzer  = 1'b0;
        lockout = 1'b0;
        case (state_q)
            S_OPEN: begin
                unlock = 1'b1;
            end
            S_ALARM: begin
                buzzer  = 1'b1;
                lockout = 1'b1;
            end
            default: ;
        endcase
    end

    assign attempts = attempts_q;
    assign state    = state_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// ============================================================================
// tb_lock_seq_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for lock_seq_ctrl with default parameters. A
// transaction-level model (stored code, attempt count) predicts the verdict
// of each submitted entry; timing of unlock / alarm windows is measured.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ============================================================================
module tb_lock_seq_ctrl;

    localparam int          NDIG          = 4;
    localparam int          MAX_TRIES     = 3;
    localparam int          UNLOCK_CYCLES = 8;
    localparam int          LOCK_CYCLES   = 16;
    localparam logic [15:0] DEFAULT_CODE  = 16'h1234;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_ALARM   = 3'd4;
    localparam logic [2:0] ST_NEWCODE = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       digit_valid;
    logic       enter;
    logic       change_req;
    logic       unlock;
    logic       buzzer;
    logic       lockout;
    logic [2:0] attempts;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_code;
    int          m_att;
    logic [3:0]  seq[$];

    always #5 clk = ~clk;

    lock_seq_ctrl #(
        .NDIG          (NDIG),
        .MAX_TRIES     (MAX_TRIES),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCK_CYCLES   (LOCK_CYCLES),
        .DEFAULT_CODE  (DEFAULT_CODE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit       (digit),
        .digit_valid (digit_valid),
        .enter       (enter),
        .change_req  (change_req),
        .unlock      (unlock),
        .buzzer      (buzzer),
        .lockout     (lockout),
        .attempts    (attempts),
        .state       (state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking of their own beyond what callers read)
    // ------------------------------------------------------------------------
    task automatic set4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        seq.delete();
        seq.push_back(a);
        seq.push_back(b);
        seq.push_back(c);
        seq.push_back(d);
    endtask

    // Drive seq then enter (optionally enter together with the last digit),
    // check the one-cycle CHECK state, and return in the first verdict cycle.
    task automatic drive_entry(input string tag, input bit merge_last);
        int n;
        n = seq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            digit       = seq[i];
            digit_valid = 1'b1;
            enter       = merge_last && (i == n - 1);
        end
        if (!(merge_last && n > 0)) begin
            @(negedge clk);
            digit_valid = 1'b0;
            enter       = 1'b1;
        end
        @(negedge clk);
        digit_valid = 1'b0;
        enter       = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== ST_CHECK) begin
            errors++;
            $display("FAIL %s check_state: got %0d expected %0d", tag, state, ST_CHECK);
        end
        checks++;
        if (unlock !== 1'b0) begin
            errors++;
            $display("FAIL %s unlock_in_check: got %0b expected 0", tag, unlock);
        end
        @(negedge clk);
    endtask

    // Count consecutive cycles of the OPEN window (alarm=0) or the ALARM
    // window (alarm=1). With poke set, keys 1,2,3,4 and enter are hammered.
    task automatic measure(input bit alarm, input bit poke, output int cnt);
        cnt = 0;
        while (cnt < 100 &&
               (alarm ? (buzzer === 1'b1 && lockout === 1'b1 && state === ST_ALARM)
                      : (unlock === 1'b1 && state === ST_OPEN))) begin
            if (poke) begin
                digit       = 4'((cnt % 4) + 1);
                digit_valid = 1'b1;
                enter       = ((cnt % 5) == 4);
            end
            cnt++;
            @(negedge clk);
        end
        digit_valid = 1'b0;
        enter       = 1'b0;
    endtask

    // One complete attempt: model predicts the verdict, then the bench
    // checks verdict state, attempts, window length and return to IDLE.
    task automatic run_attempt(input string tag, input bit merge_last, input bit poke);
        int         n;
        int         kept;
        int         cnt;
        bit         hit;
        logic [2:0] exp_state;
        n    = seq.size();
        kept = 0;
        hit  = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (merge_last && i == n - 1) continue;
            if (kept < NDIG) begin
                if (seq[i] != m_code[4*(NDIG-1-kept) +: 4]) hit = 1'b0;
                kept++;
            end
        end
        if (kept != NDIG) hit = 1'b0;
        if (hit) m_att = 0;
        else if (m_att < 7) m_att++;
        exp_state = hit ? ST_OPEN : ((m_att >= MAX_TRIES) ? ST_ALARM : ST_IDLE);

        drive_entry(tag, merge_last);

        checks++;
        if (state !== exp_state) begin
            errors++;
            $display("FAIL %s verdict_state: got %0d expected %0d", tag, state, exp_state);
        end
        checks++;
        if (attempts !== 3'(m_att)) begin
            errors++;
            $display("FAIL %s attempts: got %0d expected %0d", tag, attempts, m_att);
        end

        if (exp_state == ST_OPEN) begin
            measure(1'b0, 1'b0, cnt);
            checks++;
            if (cnt != UNLOCK_CYCLES) begin
                errors++;
                $display("FAIL %s unlock_cycles: got %0d expected %0d", tag, cnt, UNLOCK_CYCLES);
            end
        end else if (exp_state == ST_ALARM) begin
            measure(1'b1, poke, cnt);
            m_att = 0;
            checks++;
            if (cnt != LOCK_CYCLES) begin
                errors++;
                $display("FAIL %s alarm_cycles: got %0d expected %0d", tag, cnt, LOCK_CYCLES);
            end
            checks++;
            if (attempts !== 3'd0) begin
                errors++;
                $display("FAIL %s attempts_after_alarm: got %0d expected 0", tag, attempts);
            end
            if (poke) begin
                repeat (2) @(negedge clk);
            end
        end

        checks++;
        if (state !== ST_IDLE || unlock !== 1'b0 || buzzer !== 1'b0 || lockout !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: got state=%0d unlock=%0b buzzer=%0b lockout=%0b expected state=0 outputs=0",
                     tag, state, unlock, buzzer, lockout);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset       = 1'b1;
        digit       = 4'h0;
        digit_valid = 1'b0;
        enter       = 1'b0;
        change_req  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if (unlock !== 1'b0 || buzzer !== 1'b0 || lockout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got unlock=%0b buzzer=%0b lockout=%0b expected 0",
                     unlock, buzzer, lockout);
        end
        checks++;
        if (attempts !== 3'd0) begin
            errors++;
            $display("FAIL reset_attempts: got %0d expected 0", attempts);
        end
        reset  = 1'b0;
        m_code = DEFAULT_CODE;
        m_att  = 0;
        @(negedge clk);
    endtask

    task automatic test_open();
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        run_attempt("open_1234", 1'b0, 1'b0);
    endtask

    task automatic test_alarm();
        set4(4'h1, 4'h2, 4'h3, 4'h5);
        run_attempt("wrong_1", 1'b0, 1'b0);
        run_attempt("wrong_2", 1'b0, 1'b0);
        run_attempt("wrong_3_alarm", 1'b0, 1'b1);
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        run_attempt("open_after_alarm", 1'b0, 1'b0);
    endtask

    task automatic test_short_and_drop();
        seq.delete();
        seq.push_back(4'h1);
        seq.push_back(4'h2);
        seq.push_back(4'h3);
        run_attempt("short_entry", 1'b0, 1'b0);
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        seq.push_back(4'h9);
        run_attempt("fifth_dropped", 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle();
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        run_attempt("enter_beats_digit", 1'b1, 1'b0);
        run_attempt("clear_after_merge", 1'b0, 1'b0);
    endtask

`ifdef LOCK_SEQ_CTRL_CHANGE_EN
    task automatic test_code_change();
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        drive_entry("chg_open", 1'b0);
        checks++;
        if (state !== ST_OPEN) begin
            errors++;
            $display("FAIL chg_open_state: got %0d expected %0d", state, ST_OPEN);
        end
        change_req = 1'b1;
        @(negedge clk);
        change_req = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== ST_NEWCODE || unlock !== 1'b0 || lockout !== 1'b0) begin
            errors++;
            $display("FAIL chg_newcode: got state=%0d unlock=%0b lockout=%0b expected state=5 outputs=0",
                     state, unlock, lockout);
        end
        set4(4'h9, 4'h8, 4'h7, 4'h6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            digit       = seq[i];
            digit_valid = 1'b1;
        end
        @(negedge clk);
        digit_valid = 1'b0;
        enter       = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== ST_IDLE) begin
            errors++;
            $display("FAIL chg_commit_state: got %0d expected 0", state);
        end
        m_code = 16'h9876;
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        run_attempt("old_code_fails", 1'b0, 1'b0);
        set4(4'h9, 4'h8, 4'h7, 4'h6);
        run_attempt("new_code_opens", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m_code = DEFAULT_CODE;
        m_att  = 0;
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        run_attempt("default_after_reset", 1'b0, 1'b0);
    endtask
`else
    task automatic test_code_change();
        int cnt;
        set4(4'h1, 4'h2, 4'h3, 4'h4);
        drive_entry("chg_ignored", 1'b0);
        checks++;
        if (state !== ST_OPEN) begin
            errors++;
            $display("FAIL chg_ignored_open: got %0d expected %0d", state, ST_OPEN);
        end
        change_req = 1'b1;
        measure(1'b0, 1'b0, cnt);
        change_req = 1'b0;
        checks++;
        if (cnt != UNLOCK_CYCLES || state !== ST_IDLE) begin
            errors++;
            $display("FAIL chg_ignored_window: got cycles=%0d state=%0d expected cycles=%0d state=0",
                     cnt, state, UNLOCK_CYCLES);
        end
        run_attempt("code_still_default", 1'b0, 1'b0);
    endtask
`endif

    task automatic test_async_reset();
        set4(4'h1, 4'h2, 4'h3, 4'h5);
        run_attempt("pre_alarm_1", 1'b0, 1'b0);
        run_attempt("pre_alarm_2", 1'b0, 1'b0);
        drive_entry("rst_alarm", 1'b0);
        checks++;
        if (state !== ST_ALARM || attempts !== 3'd3) begin
            errors++;
            $display("FAIL rst_alarm_entered: got state=%0d attempts=%0d expected state=4 attempts=3",
                     state, attempts);
        end
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (buzzer !== 1'b0 || lockout !== 1'b0 || unlock !== 1'b0 ||
            attempts !== 3'd0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid_alarm: got buzzer=%0b lockout=%0b unlock=%0b attempts=%0d state=%0d expected all 0",
                     buzzer, lockout, unlock, attempts, state);
        end
        @(negedge clk);
        reset  = 1'b0;
        m_code = DEFAULT_CODE;
        m_att  = 0;

        set4(4'h1, 4'h2, 4'h3, 4'h4);
        drive_entry("rst_open", 1'b0);
        checks++;
        if (state !== ST_OPEN || unlock !== 1'b1) begin
            errors++;
            $display("FAIL rst_open_entered: got state=%0d unlock=%0b expected state=3 unlock=1",
                     state, unlock);
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (unlock !== 1'b0 || buzzer !== 1'b0 || lockout !== 1'b0 ||
            attempts !== 3'd0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid_open: got unlock=%0b buzzer=%0b lockout=%0b attempts=%0d state=%0d expected all 0",
                     unlock, buzzer, lockout, attempts, state);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int kind;
        int len;
        bit merge;
        bit poke;
        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 3);
            merge = 1'b0;
            poke  = 1'($urandom_range(0, 1));
            seq.delete();
            case (kind)
                0: begin
                    for (int i = 0; i < NDIG; i++) seq.push_back(m_code[4*(NDIG-1-i) +: 4]);
                end
                1: begin
                    for (int i = 0; i < NDIG; i++) seq.push_back(m_code[4*(NDIG-1-i) +: 4]);
                    len = $urandom_range(1, 2);
                    for (int i = 0; i < len; i++) seq.push_back(4'($urandom_range(0, 15)));
                end
                2: begin
                    len = $urandom_range(0, 6);
                    for (int i = 0; i < len; i++) seq.push_back(4'($urandom_range(0, 15)));
                    merge = (len > 0) && ($urandom_range(0, 3) == 0);
                end
                default: begin
                    for (int i = 0; i < NDIG - 1; i++) seq.push_back(m_code[4*(NDIG-1-i) +: 4]);
                    seq.push_back(4'($urandom_range(0, 15)));
                    merge = 1'b1;
                end
            endcase
            run_attempt($sformatf("random_%0d", t), merge, poke);
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_alarm();
        test_short_and_drop();
        test_same_cycle();
        test_code_change();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
